// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: round-robin channel sequencer for a 2-to-4 decoder.
// Each enabled channel gets a blanking gap (sel_vld low) followed by a
// dwell window (sel_vld high). sel only moves while sel_vld is low, unless
// BLANK is 0.
module digit_scan_ctrl #(
    parameter int DWELL = 8,
    parameter int BLANK = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] mask,
    output logic [1:0] sel,
    output logic       sel_vld,
    output logic       frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DWELL} state_t;

    localparam logic [15:0] D_LAST = 16'(DWELL - 1);
    localparam logic [15:0] B_LAST = (BLANK > 0) ? 16'(BLANK - 1) : 16'd0;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic        vld_q, vld_d;
    logic        fd_q, fd_d;

    logic        nxt_found;
    logic [1:0]  nxt_idx;
    logic [1:0]  cand;
    logic        do_sel;

    // Next-channel search: first set mask bit at ptr+1 .. ptr+4 (mod 4).
    // Walking from far to near lets the nearest hit win.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = 2'b00;
        cand      = 2'b00;
        for (int i = 4; i >= 1; i--) begin
            cand = ptr_q + 2'(i);
            if (mask[cand]) begin
                nxt_found = 1'b1;
                nxt_idx   = cand;
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        vld_d   = vld_q;
        fd_d    = 1'b0;
        do_sel  = 1'b0;
        if (!en) begin
            // Stopping forgets the position so a restart begins at the
            // lowest enabled channel.
            state_d = S_IDLE;
            ptr_d   = 2'b11;
            cnt_d   = '0;
            vld_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  do_sel = 1'b1;
                S_BLANK: begin
                    if (cnt_q == B_LAST) begin
                        state_d = S_DWELL;
                        cnt_d   = '0;
                        vld_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_DWELL: begin
                    if (cnt_q == D_LAST) do_sel = 1'b1;
                    else                 cnt_d  = cnt_q + 16'd1;
                end
                default: state_d = S_IDLE;
            endcase
            if (do_sel) begin
                cnt_d = '0;
                if (nxt_found) begin
                    sel_d = nxt_idx;
                    ptr_d = nxt_idx;
                    // A select straight out of IDLE starts a frame, so it
                    // never counts as a wrap.
                    fd_d  = (state_q == S_DWELL) && (nxt_idx <= ptr_q);
                    if (BLANK > 0) begin
                        state_d = S_BLANK;
                        vld_d   = 1'b0;
                    end else begin
                        state_d = S_DWELL;
                        vld_d   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                    vld_d   = 1'b0;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'b11;
            cnt_q   <= '0;
            sel_q   <= 2'b00;
            vld_q   <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            fd_q    <= fd_d;
        end
    end

    assign sel        = sel_q;
    assign sel_vld    = vld_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl: u0 runs DWELL=4/BLANK=1, u1 runs
// DWELL=3/BLANK=0.
module tb_digit_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en0, en1;
    logic [3:0] mask0, mask1;
    logic [1:0] sel0, sel1;
    logic       vld0, vld1, fd0, fd1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    digit_scan_ctrl #(.DWELL(4), .BLANK(1)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .mask(mask0),
        .sel(sel0), .sel_vld(vld0), .frame_done(fd0)
    );

    digit_scan_ctrl #(.DWELL(3), .BLANK(0)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .mask(mask1),
        .sel(sel1), .sel_vld(vld1), .frame_done(fd1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one edge on u0 and check all three outputs.
    task automatic cyc0(input string tag, input logic [1:0] s, input logic v, input logic f);
        tick();
        chk({tag, ".sel"}, 32'(sel0), 32'(s));
        chk({tag, ".vld"}, 32'(vld0), 32'(v));
        chk({tag, ".fd"},  32'(fd0),  32'(f));
    endtask

    task automatic cyc1(input string tag, input logic [1:0] s, input logic v, input logic f);
        tick();
        chk({tag, ".sel"}, 32'(sel1), 32'(s));
        chk({tag, ".vld"}, 32'(vld1), 32'(v));
        chk({tag, ".fd"},  32'(fd1),  32'(f));
    endtask

    // Drop en for one edge (back to IDLE, ptr reset), then enable with m.
    // The caller's next edge is the start edge k.
    task automatic restart0(input logic [3:0] m);
        en0 = 1'b0;
        tick();
        mask0 = m;
        en0   = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; mask0 = 4'h0; mask1 = 4'h0;
        #12;
        chk("rst.sel", 32'(sel0), 32'd0);
        chk("rst.vld", 32'(vld0), 32'd0);
        chk("rst.fd",  32'(fd0),  32'd0);
        @(negedge clk);
        rst_n = 1'b1; mask0 = 4'hF; en0 = 1'b1;

        // Full scan: n counts edges from the start edge; period 5.
        for (int n = 0; n < 23; n++)
            cyc0("full", 2'((n / 5) % 4), (n % 5) != 0, (n == 20));

        // Async reset mid-dwell (n=22 is a dwell cycle of channel 0).
        #2 rst_n = 1'b0;
        #1;
        chk("arst.sel", 32'(sel0), 32'd0);
        chk("arst.vld", 32'(vld0), 32'd0);
        chk("arst.fd",  32'(fd0),  32'd0);
        #1 rst_n = 1'b1;
        cyc0("arst_k0", 2'd0, 1'b0, 1'b0);
        cyc0("arst_k1", 2'd0, 1'b1, 1'b0);

        // Sparse mask: 1,3,1,3 with a wrap pulse on each 3->1.
        restart0(4'b1010);
        for (int n = 0; n < 21; n++)
            cyc0("sparse", ((n / 5) % 2) ? 2'd3 : 2'd1, (n % 5) != 0,
                 (n > 0) && (n % 10 == 0));

        // Stop at the 2nd dwell cycle of channel 2 (n=12).
        restart0(4'hF);
        for (int n = 0; n <= 12; n++) tick();
        chk("stop_pre.sel", 32'(sel0), 32'd2);
        chk("stop_pre.vld", 32'(vld0), 32'd1);
        en0 = 1'b0;
        cyc0("stop0", 2'd2, 1'b0, 1'b0);
        cyc0("stop1", 2'd2, 1'b0, 1'b0);
        mask0 = 4'hF; en0 = 1'b1;
        cyc0("reen0", 2'd0, 1'b0, 1'b0);
        cyc0("reen1", 2'd0, 1'b1, 1'b0);

        // Mask cleared during channel 1 dwell (n=6): dwell finishes, then IDLE.
        restart0(4'hF);
        for (int n = 0; n <= 6; n++) tick();
        mask0 = 4'h0;
        cyc0("mclr7", 2'd1, 1'b1, 1'b0);
        cyc0("mclr8", 2'd1, 1'b1, 1'b0);
        cyc0("mclr9", 2'd1, 1'b1, 1'b0);
        cyc0("mclr10", 2'd1, 1'b0, 1'b0);
        cyc0("mclr11", 2'd1, 1'b0, 1'b0);

        // Mid-dwell mask update on channel 0 (n=2): next is 3, then 0 with wrap.
        restart0(4'hF);
        for (int n = 0; n <= 2; n++) tick();
        mask0 = 4'b1001;
        cyc0("mupd3", 2'd0, 1'b1, 1'b0);
        cyc0("mupd4", 2'd0, 1'b1, 1'b0);
        cyc0("mupd5", 2'd3, 1'b0, 1'b0);
        for (int n = 6; n < 10; n++) cyc0("mupd_d3", 2'd3, 1'b1, 1'b0);
        cyc0("mupd10", 2'd0, 1'b0, 1'b1);
        cyc0("mupd11", 2'd0, 1'b1, 1'b0);

        // Single channel, zero blank on u1: sel=2, vld stays high, wrap every 3.
        mask1 = 4'b0100; en1 = 1'b1;
        for (int n = 0; n < 10; n++)
            cyc1("single", 2'd2, 1'b1, (n > 0) && (n % 3 == 0));
        en1 = 1'b0;
        cyc1("single_stop", 2'd2, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Round-robin scan sequencer that generates the 2-bit channel index consumed by the team's 2-to-4 decoder (`decoder2_4`). The decoder turns the index into one-hot enables for a 4-way multiplexed load, such as a 4-digit display or a 4-bank select. The block steps through enabled channels in order. Each channel is held for a programmable dwell time, and a blanking gap with the select qualifier low separates consecutive channels. This ensures the decoder's output only changes while it is qualified off.

## Interface

Parameters:
- DWELL, default 8: cycles each channel is held with sel_vld high; legal range 1..65535.
- BLANK, default 1: cycles with sel_vld low before each channel; legal range 0..255.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: scan enable; level-sensitive.
- mask, input, 4: per-channel enable; bit n set means channel n is scanned.
- sel, output, 2: channel index; drives decoder2_4 input i.
- sel_vld, output, 1: qualifier; the decoded enable is valid only while this is high.
- frame_done, output, 1: one-cycle pulse each time the scan wraps.

## Operation

- **State machine:** IDLE, BLANK, DWELL. Internal pointer ptr[1:0] holds the last-selected channel. A single cycle counter cnt (16 bits) is shared by BLANK and DWELL.
- **Reset (rst_n low, asynchronous):**
  - Outputs: sel=2'b00, sel_vld=0, frame_done=0.
  - Internal: state=IDLE, ptr=2'b11, cnt=0.
- **Next-channel search:**
  - Search order is ptr+1, ptr+2, ptr+3, ptr+4 (all mod 4).
  - The first index whose mask bit is set is chosen.
  - mask is sampled only on the cycle the search is performed.
  - If mask==0, no channel is found.
- **Channel select event:** performed from IDLE when en=1, and at the end of DWELL when en=1.
  - If a channel is found, sel and ptr take the new index on the same edge.
  - If BLANK>0, enter BLANK. If BLANK==0, enter DWELL directly.
  - If no channel is found, go to IDLE; sel holds its value.
- **Wrap detection:** frame_done=1 for one cycle on a select edge where new index ≤ old ptr, except the first select after leaving IDLE (ptr was reset).
- **BLANK:** sel_vld=0; lasts exactly BLANK cycles, then go to DWELL.
- **DWELL:** sel_vld=1; lasts exactly DWELL cycles, then perform a select event.
- **en deassertion:** en=0 in any state moves to IDLE on the next edge.
  - sel_vld=0 from that edge onward.
  - ptr is reset to 2'b11, so re-enabling restarts from the lowest enabled channel.
  - sel holds its value.
- **mask changes:** a mask change mid-BLANK or mid-DWELL does not abort the current channel. It takes effect at the next select event. mask→0 therefore completes the current dwell, then goes to IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing

- **Start-up:** en sampled high at edge k (from IDLE, mask≠0):
  - sel is valid after edge k.
  - sel_vld rises after edge k+BLANK and stays high for DWELL cycles.
- **Steady-state period per channel:** BLANK+DWELL cycles.
- **Decoder glitch safety:** sel changes only on the edge that enters BLANK, or on the DWELL→DWELL edge when BLANK=0.
  - With BLANK≥1, sel is stable for at least one full cycle before sel_vld rises.
  - sel is never changed while sel_vld is high, except when BLANK=0.
- **Stop:** from en low at edge k, sel_vld=0 after edge k.
- **Reset mid-operation:** outputs go to their reset values immediately, without waiting for a clock. Operation resumes like the first start once rst_n=1 and en=1.

## Test plan

1. **Reset:** assert rst_n=0 mid-DWELL (without a clock edge) -> sel=00, sel_vld=0, frame_done=0 immediately. After release with en=1, mask=1111, the first channel is 0.
2. **Full scan:** DWELL=4, BLANK=1, mask=1111, en=1 -> sel sequence 0,1,2,3,0,…, period 5 cycles. sel_vld pattern per channel is 0,1,1,1,1. frame_done pulses once, on the 3→0 select edge, and not on the initial select.
3. **Sparse mask:** mask=1010 -> sel alternates 1,3,1,3. frame_done pulses on each 3→1 edge.
4. **Single channel, zero blank:** mask=0100, BLANK=0 -> sel=2 constant, sel_vld held high continuously, frame_done pulses every DWELL cycles.
5. **Stop and mask clear:**
   - en dropped at the 2nd DWELL cycle of channel 2 -> sel_vld=0 the next cycle, sel stays 2. Re-enable with mask=1111 -> restart at channel 0.
   - Separately, mask set to 0000 mid-DWELL -> the dwell completes its full length, then IDLE with sel_vld=0.
6. **Mid-dwell mask update:** during channel 0 dwell, mask changes 1111→1001 -> the current dwell is unaffected, the next selected channel is 3, followed by 0 with a frame_done pulse.
